// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one full-add/full-subtract bit cell, LSB first, carry/borrow kept in a flop.
// Latency: start sampled on E0, bits on E1..E_WIDTH, done high for the one cycle after E_WIDTH.
// Backpressure: none; start is ignored while busy, and start during the done cycle chains a new operation.
module serial_add_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] R,
  output logic             CB
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // Operand and result shift registers, op and carry/borrow of the running operation.
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] r_sr;
  logic             op_q;
  logic             c_q;
  logic [CW-1:0]    cnt;

  // Bit-cell signals.
  logic             a_bit;
  logic             b_bit;
  logic             sum_bit;
  logic             c_next;
  logic [WIDTH-1:0] r_next;
  logic             accept;
  logic             last_bit;

  // A new operation is taken only from IDLE or the DONE cycle; RUN ignores start.
  assign accept   = start && (state != RUN);
  assign last_bit = (state == RUN) && (cnt == LAST_BIT);

  // Full-add / full-subtract bit cell on the operand LSBs.
  always_comb begin
    a_bit   = a_sr[0];
    b_bit   = b_sr[0];
    sum_bit = a_bit ^ b_bit ^ c_q;
    if (op_q) begin
      c_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & c_q);
    end else begin
      c_next = (a_bit & b_bit) | ((a_bit ^ b_bit) & c_q);
    end
    r_next = {sum_bit, r_sr[WIDTH-1:1]};
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and status outputs.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_bit) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (accept) begin
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operand capture on accept, then one shift/accumulate step per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr <= '0;
      b_sr <= '0;
      r_sr <= '0;
      op_q <= 1'b0;
      c_q  <= 1'b0;
      cnt  <= '0;
    end else if (accept) begin
      a_sr <= A;
      b_sr <= B;
      r_sr <= '0;
      op_q <= op;
      c_q  <= 1'b0;
      cnt  <= '0;
    end else if (state == RUN) begin
      a_sr <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr <= {1'b0, b_sr[WIDTH-1:1]};
      r_sr <= r_next;
      c_q  <= c_next;
      cnt  <= cnt + CW'(1);
    end
  end

  // Result and carry/borrow update only when the final bit is processed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      R  <= '0;
      CB <= 1'b0;
    end else if (last_bit) begin
      R  <= r_next;
      CB <= c_next;
    end
  end

endmodule
